mem_reg_bank: RTL
=================

Name: mem_reg_bank

Overview:
- Parametrised bank of NUM_REGS memory-mapped registers, each DATA_SIZE bits wide, on the soft-CPU memory bus.
- Successor to the single-register read/write slot. It adds:
  - word addressing;
  - a registered ready handshake;
  - a second write port for game logic;
  - per-register sticky update flags;
  - optional frame-synchronous commit.
- Sits between the CPU bus decoder and game/video logic (sprite positions, score, lives).

Parameters:
- DATA_SIZE, 6, bits per register (1..32).
- NUM_REGS, 8, number of registers (2..64).
- ADDR_W, $clog2(NUM_REGS), word-address width. Derived; do not override.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- mem_sel  input  1  CPU selects this bank; held until mem_ready is seen.
- mem_addr  input  ADDR_W  word index.
- we  input  1  CPU write enable, qualified by mem_sel.
- mem_data_i  input  DATA_SIZE  CPU write data.
- mem_ready  output  1  one-cycle transaction acknowledge.
- mem_data_o  output  32  read data, zero-extended, valid while mem_ready=1.
- hw_we  input  1  game-logic write strobe.
- hw_addr  input  ADDR_W  game-logic write index.
- hw_data  input  DATA_SIZE  game-logic write data.
- upd_clr  input  NUM_REGS  per-register update-flag clear.
- upd_flags  output  NUM_REGS  sticky "CPU wrote this register" flags.
- regs_flat  output  NUM_REGS*DATA_SIZE  live register contents; reg i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- vsync  input  1  frame-start pulse. Used only with the optional feature; ignored otherwise.

Behaviour:
- Reset (async, reset_n=0):
  - all registers, shadows, upd_flags, mem_ready and mem_data_o go to 0;
  - FSM goes to IDLE.
  - Reset mid-transaction aborts it; the pending write is lost.
  - After release, a still-high mem_sel starts a fresh transaction.
- FSM states: IDLE, ACK, HOLD.
- IDLE:
  - On mem_sel=1: capture the access this cycle and go to ACK.
  - If we=1: write mem_data_i to register mem_addr at this edge.
  - Always: latch read data for mem_addr into mem_data_o. A read in a write cycle returns the old value.
- ACK:
  - mem_ready=1 for exactly this cycle.
  - Go to HOLD if mem_sel is still 1, else IDLE.
- HOLD:
  - mem_ready=0; no new capture.
  - Return to IDLE when mem_sel=0.
  - This guarantees one access per mem_sel assertion.
- Latency: mem_ready rises 1 cycle after mem_sel is first seen high.
- mem_data_o holds its value outside ACK; consumers sample only while mem_ready=1.
- Out-of-range address (mem_addr >= NUM_REGS, possible when NUM_REGS is not a power of 2): write ignored, read returns 0, still acknowledged.
- Game-logic write: hw_we=1 writes hw_data to register hw_addr at the edge, independent of the FSM. Out-of-range hw_addr is ignored.
- Simultaneous CPU and game-logic write to the same register in the same edge: the CPU write wins; the hw write is dropped. Different registers: both take effect.
- upd_flags[i]:
  - set on a CPU write to register i;
  - cleared by upd_clr[i];
  - set wins over clear in the same cycle;
  - hw writes never set flags.
- Width rule: read data is {(32-DATA_SIZE) zeros, reg}. CPU write uses all DATA_SIZE bits; no byte strobes.

Optional Feature:
- Macro: MEM_REG_BANK_VSYNC_COMMIT_EN.
- With the macro:
  - CPU writes go to a per-register shadow and set a per-register pending bit; regs_flat is unchanged.
  - On vsync=1, every pending shadow is copied to its live register in one edge. Pending bits clear, and upd_flags set at the commit rather than at the write.
  - CPU reads return the shadow.
  - hw writes update both live and shadow, and do not touch pending.
  - A CPU write coinciding with vsync to the same register commits the new value in that same edge.
  - Shadows reset to 0.
- Without the macro: no shadows, vsync ignored, behaviour as described above.

Decomposition:
- Package mem_reg_bank_pkg holds:
  - FSM state typedef (IDLE/ACK/HOLD);
  - the zero-extension helper function;
  - constants for the parameter limits.
- One sub-module is natural: mem_reg_cell, a single register plus optional shadow, pending bit and update flag. Instantiate it NUM_REGS times via generate; the top keeps the FSM and the read mux.

Test Plan:
- Reset and CPU write/read:
  - Reset with defaults: all regs_flat=0, upd_flags=0, mem_ready=0.
  - CPU write addr 3 data 6'h2A: mem_ready high exactly 1 cycle after mem_sel; regs_flat[23:18]=6'h2A; upd_flags=8'h08.
  - CPU read addr 3: mem_data_o=32'h0000002A while mem_ready=1.
- Hold and re-arm: hold mem_sel high for 5 cycles with we=1 and changing data. Exactly one mem_ready pulse; only the first data is written. Drop mem_sel for 1 cycle, reassert; the next transaction is acked.
- Write collision:
  - Same edge, CPU writes addr 1 = 6'h11 and hw writes addr 1 = 6'h22: reg1=6'h11.
  - Repeat with hw_addr=2: reg1=6'h11 and reg2=6'h22. upd_flags bit2 stays 0.
- Flag set/clear race: upd_clr=8'hFF in the same cycle as a CPU write to addr 5. Flag bit5=1 and all other bits 0 afterwards. Then upd_clr[5] alone clears bit 5.
- Reset mid-transaction: assert reset_n=0 during ACK. mem_ready drops immediately and the FSM is in IDLE. Release with mem_sel=1 and we=0: one new ack.
- With MEM_REG_BANK_VSYNC_COMMIT_EN:
  - CPU write addr 0 = 6'h3F: regs_flat[5:0] stays 0; read addr 0 returns 32'h3F; upd_flags bit0=0.
  - Pulse vsync: regs_flat[5:0]=6'h3F next edge and upd_flags bit0=1.
  - A second vsync with no pending writes changes nothing.

Source files
------------

// File: rtl/mem_reg_bank_pkg.sv
// Shared types and helpers for the mem_reg_bank register file.
// Optional build macro: MEM_REG_BANK_VSYNC_COMMIT_EN (frame-synchronous commit).
package mem_reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } bank_state_e;

    localparam int DATA_SIZE_MIN = 1;
    localparam int DATA_SIZE_MAX = 32;
    localparam int NUM_REGS_MIN  = 2;
    localparam int NUM_REGS_MAX  = 64;

    // Keeps only the low 'width' bits so the bus never sees stale upper bits.
    function automatic logic [31:0] zext_data(input logic [31:0] raw, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return raw & mask;
    endfunction

endpackage

// File: rtl/mem_reg_cell.sv
// One bank register with its sticky update flag (and, with
// MEM_REG_BANK_VSYNC_COMMIT_EN, a shadow copy plus pending bit).
module mem_reg_cell
    import mem_reg_bank_pkg::*;
#(
    parameter int DATA_SIZE = 6
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cpu_we,
    input  logic [DATA_SIZE-1:0] cpu_data,
    input  logic                 hw_we,
    input  logic [DATA_SIZE-1:0] hw_data,
    input  logic                 vsync,
    input  logic                 upd_clr,
    output logic [DATA_SIZE-1:0] live,
    output logic [DATA_SIZE-1:0] rd_val,
    output logic                 upd_flag
);

`ifdef MEM_REG_BANK_VSYNC_COMMIT_EN
    logic [DATA_SIZE-1:0] shadow;
    logic                 pending;
    logic                 commit;

    // A CPU write landing on the vsync edge is committed immediately.
    assign commit = vsync && (pending || cpu_we);
    assign rd_val = shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live     <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            upd_flag <= 1'b0;
        end else begin
            if (cpu_we)
                shadow <= cpu_data;
            else if (hw_we)
                shadow <= hw_data;

            if (commit)
                live <= cpu_we ? cpu_data : shadow;
            else if (hw_we)
                live <= hw_data;

            if (commit)
                pending <= 1'b0;
            else if (cpu_we)
                pending <= 1'b1;

            if (commit)
                upd_flag <= 1'b1;
            else if (upd_clr)
                upd_flag <= 1'b0;
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign rd_val       = live;

    // CPU has priority over game logic on the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live     <= '0;
            upd_flag <= 1'b0;
        end else begin
            if (cpu_we)
                live <= cpu_data;
            else if (hw_we)
                live <= hw_data;

            if (cpu_we)
                upd_flag <= 1'b1;
            else if (upd_clr)
                upd_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/mem_reg_bank.sv
// Memory-mapped register bank: CPU bus FSM with one-cycle ack, read mux,
// game-logic write port. Optional macro: MEM_REG_BANK_VSYNC_COMMIT_EN.
module mem_reg_bank
    import mem_reg_bank_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mem_sel,
    input  logic [ADDR_W-1:0]             mem_addr,
    input  logic                          we,
    input  logic [DATA_SIZE-1:0]          mem_data_i,
    output logic                          mem_ready,
    output logic [31:0]                   mem_data_o,
    input  logic                          hw_we,
    input  logic [ADDR_W-1:0]             hw_addr,
    input  logic [DATA_SIZE-1:0]          hw_data,
    input  logic [NUM_REGS-1:0]           upd_clr,
    output logic [NUM_REGS-1:0]           upd_flags,
    output logic [NUM_REGS*DATA_SIZE-1:0] regs_flat,
    input  logic                          vsync
);

    bank_state_e                   state, state_next;
    logic                          capture;
    logic                          cpu_wr;
    logic [31:0]                   rd_word;
    logic [NUM_REGS*DATA_SIZE-1:0] rd_flat;

    // Only IDLE captures, so a held mem_sel yields exactly one access.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_sel) begin
                    capture    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = mem_sel ? HOLD : IDLE;
            HOLD:    if (!mem_sel) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cpu_wr    = capture && we;
    assign mem_ready = (state == ACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_data_o <= '0;
        end else begin
            state <= state_next;
            if (capture)
                mem_data_o <= rd_word;
        end
    end

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (mem_addr == ADDR_W'(i))
                rd_word = zext_data(32'(rd_flat[i*DATA_SIZE +: DATA_SIZE]), DATA_SIZE);
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        mem_reg_cell #(
            .DATA_SIZE(DATA_SIZE)
        ) u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .cpu_we  (cpu_wr && (mem_addr == ADDR_W'(g))),
            .cpu_data(mem_data_i),
            .hw_we   (hw_we && (hw_addr == ADDR_W'(g))),
            .hw_data (hw_data),
            .vsync   (vsync),
            .upd_clr (upd_clr[g]),
            .live    (regs_flat[g*DATA_SIZE +: DATA_SIZE]),
            .rd_val  (rd_flat[g*DATA_SIZE +: DATA_SIZE]),
            .upd_flag(upd_flags[g])
        );
    end

endmodule
